// File: rtl/prog_sequencer.sv
// Program loader and run supervisor: streams words into instruction memory, then pulses
// CPU start and times the run. Define PROG_SEQ_PAD_HALT_EN to append HALT_WORD after a load.
module prog_sequencer #(
    parameter int IW = 9,
    parameter int AW = 8,
    parameter int CW = 16,
    parameter int TIMEOUT = 1000,
    parameter logic [IW-1:0] HALT_WORD = IW'(9'h1FF)
) (
    input  logic          clk,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [IW-1:0] ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic          go,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [IW-1:0] im_wdata,
    output logic          cpu_start,
    input  logic          cpu_done,
    output logic          busy,
    output logic          pass,
    output logic          tmo,
    output logic          ovf,
    output logic [AW:0]   prog_len,
    output logic [CW-1:0] cycles
);
`ifdef PROG_SEQ_PAD_HALT_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_RUN, S_FIN} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIN} state_t;
`endif

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        state;
    state_t        last_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [AW:0]   wr_idx;
    logic [AW:0]   len_nxt;
    logic          hs;
    logic          room;

    assign ld_ready = !start && (state == S_IDLE || state == S_LOAD || state == S_FIN);
    assign hs       = ld_valid && ld_ready;
    assign busy     = !(state == S_IDLE || state == S_FIN);
    assign cnt_inc  = cnt + 1'b1;

    // A handshake outside LOAD always starts a fresh program at index 0.
    assign wr_idx  = (state == S_LOAD) ? prog_len : '0;
    assign room    = wr_idx < DEPTH;
    assign len_nxt = room ? wr_idx + 1'b1 : wr_idx;

`ifdef PROG_SEQ_PAD_HALT_EN
    assign last_state = (len_nxt < DEPTH) ? S_PAD : S_IDLE;
`else
    assign last_state = S_IDLE;
`endif

    always_ff @(posedge clk) begin
        if (start) begin
            state     <= S_IDLE;
            cpu_start <= 1'b1;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            pass      <= 1'b0;
            tmo       <= 1'b0;
            ovf       <= 1'b0;
            prog_len  <= '0;
            cycles    <= '0;
            cnt       <= '0;
        end else begin
            im_we <= 1'b0;
            if (hs) begin
                if (state != S_LOAD) begin
                    pass <= 1'b0;
                    tmo  <= 1'b0;
                    ovf  <= 1'b0;
                end
                if (room) begin
                    im_we    <= 1'b1;
                    im_addr  <= wr_idx[AW-1:0];
                    im_wdata <= ld_data;
                end else begin
                    ovf <= 1'b1;
                end
                prog_len <= len_nxt;
                state    <= ld_last ? last_state : S_LOAD;
            end else begin
                case (state)
                    S_IDLE, S_FIN: begin
                        if (go) begin
                            state  <= S_RUN;
                            cnt    <= '0;
                            cycles <= '0;
                            pass   <= 1'b0;
                            tmo    <= 1'b0;
                        end
                    end
`ifdef PROG_SEQ_PAD_HALT_EN
                    S_PAD: begin
                        im_we    <= 1'b1;
                        im_addr  <= prog_len[AW-1:0];
                        im_wdata <= HALT_WORD;
                        state    <= S_IDLE;
                    end
`endif
                    // cpu_start doubles as the entry-cycle marker; done is ignored there.
                    S_RUN: begin
                        if (cpu_start) begin
                            cpu_start <= 1'b0;
                        end else if (cpu_done || cnt_inc == CW'(TIMEOUT)) begin
                            cycles    <= cnt_inc;
                            pass      <= cpu_done;
                            tmo       <= !cpu_done;
                            cpu_start <= 1'b1;
                            state     <= S_FIN;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
